// File: rtl/auth_pkg.sv
// Shared constants and types for the account authenticator.
// Account table, mode encodings, index sentinel and lockout parameters.
package auth_pkg;

    localparam int unsigned NUM_ACCOUNTS = 10;
    localparam int unsigned ACC_W        = 12;
    localparam int unsigned PIN_W        = 4;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned CNT_W        = 2;

    localparam logic MODE_FIND = 1'b0;
    localparam logic MODE_AUTH = 1'b1;

    localparam logic [IDX_W-1:0] NO_INDEX       = 4'hF;
    localparam logic [CNT_W-1:0] LOCK_THRESHOLD = 2'd3;

    // Entry i: account 1000 + 111*i, PIN (i+1) mod 16.
    localparam logic [ACC_W-1:0] ACC_TABLE [NUM_ACCOUNTS] = '{
        12'd1000, 12'd1111, 12'd1222, 12'd1333, 12'd1444,
        12'd1555, 12'd1666, 12'd1777, 12'd1888, 12'd1999
    };

    localparam logic [PIN_W-1:0] PIN_TABLE [NUM_ACCOUNTS] = '{
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8, 4'd9, 4'd10
    };

    typedef struct packed {
        logic [ACC_W-1:0] acc_number;
        logic [PIN_W-1:0] pin;
    } attempt_t;

    localparam attempt_t ATTEMPT_RESET = 16'hFFFF;

endpackage

// File: rtl/auth_lookup.sv
// Combinational compare of an account number (and PIN) against the fixed table.
module auth_lookup
    import auth_pkg::*;
(
    input  logic [ACC_W-1:0] acc_number,
    input  logic [PIN_W-1:0] pin,
    output logic             hit,
    output logic [IDX_W-1:0] hit_index,
    output logic             pin_ok
);

    // Table entries are unique, so at most one iteration can assign.
    always_comb begin
        hit       = 1'b0;
        hit_index = NO_INDEX;
        pin_ok    = 1'b0;
        for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
            if (acc_number == ACC_TABLE[i]) begin
                hit       = 1'b1;
                hit_index = IDX_W'(i);
                pin_ok    = (pin == PIN_TABLE[i]);
            end
        end
    end

endmodule

// File: rtl/authenticator.sv
// Account finder / PIN authenticator with a registered, one-cycle result.
// Optional per-account lockout after repeated wrong PINs: define AUTH_LOCKOUT_EN.
module authenticator
    import auth_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] acc_number,
    input  logic [PIN_W-1:0] pin,
    input  logic             mode,
    input  logic             deauth,
    output logic             match,
    output logic [IDX_W-1:0] acc_index
);

    logic             hit;
    logic [IDX_W-1:0] hit_index;
    logic             pin_ok;
    logic             locked_c;
    logic             match_c;

    auth_lookup u_lookup (
        .acc_number (acc_number),
        .pin        (pin),
        .hit        (hit),
        .hit_index  (hit_index),
        .pin_ok     (pin_ok)
    );

`ifdef AUTH_LOCKOUT_EN
    logic [NUM_ACCOUNTS-1:0][CNT_W-1:0] fail_cnt;
    logic [NUM_ACCOUNTS-1:0][CNT_W-1:0] fail_cnt_nxt;
    logic [NUM_ACCOUNTS-1:0]            lock_flags;
    logic [NUM_ACCOUNTS-1:0]            lock_flags_nxt;
    attempt_t                           last_attempt;
    attempt_t                           last_attempt_nxt;
    attempt_t                           cur_attempt;
    logic                               attempt_c;

    assign cur_attempt = '{acc_number: acc_number, pin: pin};

    // Holding the same credentials for several cycles counts as one attempt.
    assign attempt_c = (mode == MODE_AUTH) && !deauth && (cur_attempt != last_attempt);

    always_comb begin
        locked_c = 1'b0;
        for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
            if (hit && (hit_index == IDX_W'(i))) begin
                locked_c = lock_flags[i];
            end
        end
    end

    // Failure counting; a locked account is frozen until reset.
    always_comb begin
        fail_cnt_nxt     = fail_cnt;
        lock_flags_nxt   = lock_flags;
        last_attempt_nxt = last_attempt;
        if (attempt_c) begin
            last_attempt_nxt = cur_attempt;
            for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
                if (hit && (hit_index == IDX_W'(i)) && !lock_flags[i]) begin
                    if (pin_ok) begin
                        fail_cnt_nxt[i] = '0;
                    end else begin
                        fail_cnt_nxt[i] = fail_cnt[i] + CNT_W'(1);
                        if (fail_cnt_nxt[i] == LOCK_THRESHOLD) begin
                            lock_flags_nxt[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt     <= '0;
            lock_flags   <= '0;
            last_attempt <= ATTEMPT_RESET;
        end else begin
            fail_cnt     <= fail_cnt_nxt;
            lock_flags   <= lock_flags_nxt;
            last_attempt <= last_attempt_nxt;
        end
    end
`else
    assign locked_c = 1'b0;
`endif

    always_comb begin
        match_c = 1'b0;
        if (hit) begin
            if (mode == MODE_AUTH) begin
                match_c = pin_ok && !locked_c;
            end else begin
                match_c = 1'b1;
            end
        end
    end

    // Reset beats deauth, deauth beats any lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            match     <= 1'b0;
            acc_index <= NO_INDEX;
        end else if (deauth) begin
            match     <= 1'b0;
            acc_index <= NO_INDEX;
        end else begin
            match     <= match_c;
            acc_index <= match_c ? hit_index : NO_INDEX;
        end
    end

endmodule

// File: tb/tb_authenticator.sv
// Self-checking bench for authenticator: directed scenarios plus randomized traffic
// against a behavioural model of the account table and lockout rules.
module tb_authenticator;

`ifdef AUTH_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic        mode;
    logic        deauth;
    logic        match;
    logic [3:0]  acc_index;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_locked [10];
    int          m_fails  [10];
    logic [15:0] m_last;

    authenticator dut (
        .clk        (clk),
        .rst        (rst),
        .acc_number (acc_number),
        .pin        (pin),
        .mode       (mode),
        .deauth     (deauth),
        .match      (match),
        .acc_index  (acc_index)
    );

    always #5 clk = ~clk;

    function automatic int find_idx(input logic [11:0] a);
        for (int i = 0; i < 10; i++) begin
            if (int'(a) == 1000 + 111 * i) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] pin_of(input int i);
        return 4'((i + 1) % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_locked[i] = 1'b0;
            m_fails[i]  = 0;
        end
        m_last = 16'hFFFF;
    endtask

    // Drive one cycle of inputs, predict the registered result, advance the model.
    task automatic cycle(input logic r, input logic [11:0] a, input logic [3:0] p,
                         input logic m, input logic d,
                         output logic em, output logic [3:0] ei);
        int idx;
        rst = r; acc_number = a; pin = p; mode = m; deauth = d;
        idx = find_idx(a);
        em = 1'b0;
        ei = 4'hF;
        if (r) begin
            model_reset();
        end else begin
            if (!d && idx >= 0) begin
                if (!m || (p == pin_of(idx) && !m_locked[idx])) begin
                    em = 1'b1;
                    ei = 4'(idx);
                end
            end
            if (LOCKOUT && m && !d && {a, p} != m_last) begin
                m_last = {a, p};
                if (idx >= 0 && !m_locked[idx]) begin
                    if (p == pin_of(idx)) m_fails[idx] = 0;
                    else begin
                        m_fails[idx]++;
                        if (m_fails[idx] >= 3) m_locked[idx] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic em; logic [3:0] ei;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 12'd1333, 4'd4, 1'b0, 1'b0, em, ei);
            n_checks++;
            if (match !== 1'b0 || acc_index !== 4'hF) begin
                n_fail++;
                $display("FAIL reset_state: match=%b idx=%h expected match=0 idx=f", match, acc_index);
            end
        end
    endtask

    task automatic test_find();
        logic em; logic [3:0] ei;
        cycle(1'b0, 12'd1333, 4'($urandom_range(0, 15)), 1'b0, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd3) begin
            n_fail++;
            $display("FAIL find_1333: match=%b idx=%h expected match=1 idx=3", match, acc_index);
        end
        cycle(1'b0, 12'd1234, 4'($urandom_range(0, 15)), 1'b0, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL find_1234: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 12'(1000 + 111 * i), 4'($urandom_range(0, 15)), 1'b0, 1'b0, em, ei);
            n_checks++;
            if (match !== 1'b1 || acc_index !== 4'(i)) begin
                n_fail++;
                $display("FAIL find_entry_%0d: match=%b idx=%h expected match=1 idx=%h",
                         i, match, acc_index, 4'(i));
            end
        end
        // Neighbours of table entries must miss
        cycle(1'b0, 12'd999, 4'd0, 1'b0, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL find_999: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
        cycle(1'b0, 12'd2000, 4'd0, 1'b0, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL find_2000: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
    endtask

    task automatic test_auth();
        logic em; logic [3:0] ei;
        cycle(1'b0, 12'd1999, 4'd10, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd9) begin
            n_fail++;
            $display("FAIL auth_1999_ok: match=%b idx=%h expected match=1 idx=9", match, acc_index);
        end
        cycle(1'b0, 12'd1999, 4'd9, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL auth_1999_badpin: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
        cycle(1'b0, 12'd1234, 4'd5, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL auth_unknown: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
    endtask

    task automatic test_deauth();
        logic em; logic [3:0] ei;
        cycle(1'b0, 12'd1000, 4'd1, 1'b1, 1'b1, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL deauth_auth: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
        cycle(1'b0, 12'd1000, 4'd1, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd0) begin
            n_fail++;
            $display("FAIL deauth_release: match=%b idx=%h expected match=1 idx=0", match, acc_index);
        end
        cycle(1'b0, 12'd1333, 4'd0, 1'b0, 1'b1, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL deauth_find: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
    endtask

    task automatic test_lockout();
        logic em; logic [3:0] ei;
        logic [3:0] wrong [3];
        wrong[0] = 4'd3; wrong[1] = 4'd4; wrong[2] = 4'd5;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 12'd1111, wrong[k], 1'b1, 1'b0, em, ei);
            n_checks++;
            if (match !== 1'b0 || acc_index !== 4'hF) begin
                n_fail++;
                $display("FAIL lock_wrong_%0d: match=%b idx=%h expected match=0 idx=f",
                         k, match, acc_index);
            end
        end
        cycle(1'b0, 12'd1111, 4'd2, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== !LOCKOUT || acc_index !== (LOCKOUT ? 4'hF : 4'd1)) begin
            n_fail++;
            $display("FAIL lock_correct_pin: match=%b idx=%h expected match=%b", match, acc_index, !LOCKOUT);
        end
        cycle(1'b0, 12'd1111, 4'd2, 1'b0, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd1) begin
            n_fail++;
            $display("FAIL lock_find: match=%b idx=%h expected match=1 idx=1", match, acc_index);
        end
        cycle(1'b0, 12'd1111, 4'd2, 1'b1, 1'b1, em, ei);
        cycle(1'b0, 12'd1111, 4'd2, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== !LOCKOUT) begin
            n_fail++;
            $display("FAIL lock_after_deauth: match=%b idx=%h expected match=%b", match, acc_index, !LOCKOUT);
        end
        cycle(1'b1, 12'd1111, 4'd2, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1111, 4'd2, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd1) begin
            n_fail++;
            $display("FAIL lock_cleared_by_rst: match=%b idx=%h expected match=1 idx=1", match, acc_index);
        end
        // Success resets the count: two wrong, good, two wrong, good must still match
        cycle(1'b0, 12'd1222, 4'd7, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1222, 4'd8, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1222, 4'd3, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1222, 4'd7, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1222, 4'd8, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1222, 4'd3, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd2) begin
            n_fail++;
            $display("FAIL lock_success_clears: match=%b idx=%h expected match=1 idx=2", match, acc_index);
        end
        // A held wrong PIN is a single attempt
        for (int k = 0; k < 4; k++) cycle(1'b0, 12'd1444, 4'd7, 1'b1, 1'b0, em, ei);
        cycle(1'b0, 12'd1444, 4'd5, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd4) begin
            n_fail++;
            $display("FAIL lock_held_input: match=%b idx=%h expected match=1 idx=4", match, acc_index);
        end
    endtask

    task automatic test_reset_mid();
        logic em; logic [3:0] ei;
        cycle(1'b0, 12'd1555, 4'd6, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd5) begin
            n_fail++;
            $display("FAIL rstmid_pre: match=%b idx=%h expected match=1 idx=5", match, acc_index);
        end
        cycle(1'b1, 12'd1555, 4'd6, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b0 || acc_index !== 4'hF) begin
            n_fail++;
            $display("FAIL rstmid_rst: match=%b idx=%h expected match=0 idx=f", match, acc_index);
        end
        cycle(1'b0, 12'd1555, 4'd6, 1'b1, 1'b0, em, ei);
        n_checks++;
        if (match !== 1'b1 || acc_index !== 4'd5) begin
            n_fail++;
            $display("FAIL rstmid_post: match=%b idx=%h expected match=1 idx=5", match, acc_index);
        end
    endtask

    task automatic test_back_to_back();
        logic em; logic [3:0] ei;
        logic        r, m, d;
        logic [11:0] a;
        logic [3:0]  p;
        int          i;
        for (int n = 0; n < 600; n++) begin
            i = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 3) != 0) ? 12'(1000 + 111 * i) : 12'($urandom_range(0, 4095));
            p = ($urandom_range(0, 1) != 0) ? pin_of(i) : 4'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 49) == 0);
            cycle(r, a, p, m, d, em, ei);
            n_checks++;
            if (match !== em || acc_index !== ei) begin
                n_fail++;
                $display("FAIL random_%0d: acc=%0d pin=%0d mode=%b deauth=%b rst=%b got match=%b idx=%h expected match=%b idx=%h",
                         n, a, p, m, d, r, match, acc_index, em, ei);
            end
        end
    endtask

    initial begin
        rst = 1'b1; acc_number = '0; pin = '0; mode = 1'b0; deauth = 1'b0;
        model_reset();
        test_reset();
        test_find();
        test_auth();
        test_deauth();
        test_lockout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
